// File: rtl/shreg_ctrl.sv
// Sequencer for an external load/shift register: accepts a word, loads it, times the
// WIDTH shift cycles and pulses done. Optional parity cycle via SHREG_CTRL_PARITY_EN.
module shreg_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic             sh_ld,
  output logic [WIDTH-1:0] sh_d,
  input  logic [WIDTH-1:0] sh_q,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
`ifdef SHREG_CTRL_PARITY_EN
    PARITY,
`endif
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] word_r;

  // Only the MSB of the register is observed; the rest is deliberately unused.
  logic unused_sh_q;
  assign unused_sh_q = ^sh_q[WIDTH-2:0];

  assign in_ready = (state == IDLE);

`ifdef SHREG_CTRL_PARITY_EN
  assign ser_bit = (state == PARITY) ? ^word_r : sh_q[WIDTH-1];
`else
  assign ser_bit = sh_q[WIDTH-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      word_r    <= '0;
      sh_ld     <= 1'b0;
      sh_d      <= '0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments in the
      // same edge, so the pulse outputs drop unless a branch re-asserts them.
      sh_ld <= 1'b0;
      sh_d  <= '0;
      done  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (in_valid) begin
            word_r <= in_data;
            state  <= LOAD;
            sh_ld  <= 1'b1;
            sh_d   <= in_data;
            busy   <= 1'b1;
          end
        end

        LOAD: begin
          if (abort) begin
            state     <= IDLE;
            sh_ld     <= 1'b1;
            busy      <= 1'b0;
            ser_valid <= 1'b0;
          end else begin
            state     <= SHIFT;
            cnt       <= '0;
            ser_valid <= 1'b1;
          end
        end

        SHIFT: begin
          if (abort) begin
            state     <= IDLE;
            sh_ld     <= 1'b1;
            busy      <= 1'b0;
            ser_valid <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
`ifdef SHREG_CTRL_PARITY_EN
              state <= PARITY;
`else
              state     <= DONE;
              ser_valid <= 1'b0;
              done      <= 1'b1;
`endif
            end
          end
        end

`ifdef SHREG_CTRL_PARITY_EN
        PARITY: begin
          if (abort) begin
            state     <= IDLE;
            sh_ld     <= 1'b1;
            busy      <= 1'b0;
            ser_valid <= 1'b0;
          end else begin
            state     <= DONE;
            ser_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
`endif

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          ser_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shreg_ctrl.sv
// Directed bench for shreg_ctrl with a behavioural shreg model closing the loop.
// Honours SHREG_CTRL_PARITY_EN for the parity-cycle checks.
module tb_shreg_ctrl;

  localparam int WIDTH = 8;
`ifdef SHREG_CTRL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             abort;
  logic             sh_ld;
  logic [WIDTH-1:0] sh_d;
  logic [WIDTH-1:0] sh_q = '0;
  logic             ser_bit;
  logic             ser_valid;
  logic             busy;
  logic             done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int cyc = 0;

  shreg_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .abort(abort), .sh_ld(sh_ld), .sh_d(sh_d),
    .sh_q(sh_q), .ser_bit(ser_bit), .ser_valid(ser_valid), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural shreg: load or shift-left with zero fill, no reset.
  always @(posedge clk) begin
    if (sh_ld) sh_q <= sh_d;
    else       sh_q <= {sh_q[WIDTH-2:0], 1'b0};
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one word from IDLE and checks every cycle until back in IDLE.
  // hold keeps in_valid high; abort_done pulses abort during the DONE cycle.
  task automatic send_word(input logic [WIDTH-1:0] w, input bit hold, input bit abort_done,
                           output int accept_cyc);
    logic [WIDTH-1:0] word;
    word     = w;
    in_valid = 1'b1;
    in_data  = word;
    check("idle_ready", in_ready, 1);
    step();
    accept_cyc = cyc;
    if (!hold) in_valid = 1'b0;
    check("load_sh_ld", sh_ld, 1);
    check("load_sh_d", sh_d, word);
    check("load_busy", busy, 1);
    check("load_ready", in_ready, 0);
    check("load_ser_valid", ser_valid, 0);
    step();
    for (int i = 0; i < WIDTH; i++) begin
      check("shift_ser_valid", ser_valid, 1);
      check("shift_ser_bit", ser_bit, word[WIDTH-1-i]);
      check("shift_ready", in_ready, 0);
      check("shift_done", done, 0);
      check("shift_sh_ld", sh_ld, 0);
      step();
    end
    if (PAR == 1) begin
      check("par_ser_valid", ser_valid, 1);
      check("par_ser_bit", ser_bit, ^word);
      check("par_done", done, 0);
      step();
    end
    check("done_pulse", done, 1);
    check("done_ser_valid", ser_valid, 0);
    check("done_busy", busy, 1);
    check("done_ready", in_ready, 0);
    if (abort_done) abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle_done_low", done, 0);
    check("idle_busy", busy, 0);
    check("idle_ready_back", in_ready, 1);
    check("idle_sh_ld", sh_ld, 0);
  endtask

  initial begin
    int t0, t1, dc;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    abort    = 1'b0;
    step();
    step();
    check("rst_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_sh_ld", sh_ld, 0);
    check("rst_sh_d", sh_d, 0);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    step();

    // Single word
    dc = done_cnt;
    send_word(8'h7F, 1'b0, 1'b0, t0);
    check("single_done_cnt", done_cnt - dc, 1);

    // Back-to-back with in_valid held
    dc = done_cnt;
    send_word(8'hA5, 1'b1, 1'b0, t0);
    send_word(8'h3C, 1'b0, 1'b0, t1);
    check("b2b_done_cnt", done_cnt - dc, 2);
    check("b2b_period", t1 - t0, WIDTH + 3 + PAR);

    // Abort on the 4th SHIFT cycle
    dc       = done_cnt;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("abort_pre_ser_valid", ser_valid, 1);
    check("abort_pre_sh_q", sh_q, 8'hF8);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_sh_ld", sh_ld, 1);
    check("abort_sh_d", sh_d, 0);
    check("abort_busy", busy, 0);
    check("abort_ser_valid", ser_valid, 0);
    check("abort_ready", in_ready, 1);
    step();
    check("abort_sh_q", sh_q, 0);
    check("abort_sh_ld_low", sh_ld, 0);
    check("abort_ser_bit", ser_bit, 0);
    step();
    check("abort_no_done", done_cnt - dc, 0);

    // Abort in IDLE is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_sh_ld", sh_ld, 0);
    check("idle_abort_ready", in_ready, 1);

    // Abort in DONE is ignored; done still pulses
    dc = done_cnt;
    send_word(8'h96, 1'b0, 1'b1, t0);
    check("done_abort_cnt", done_cnt - dc, 1);

`ifdef SHREG_CTRL_PARITY_EN
    send_word(8'h07, 1'b0, 1'b0, t0);
    send_word(8'h03, 1'b0, 1'b0, t0);
`endif

    // Asynchronous reset mid-SHIFT
    in_valid = 1'b1;
    in_data  = 8'h7F;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("mid_ser_valid", ser_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mreset_ready", in_ready, 1);
    check("mreset_busy", busy, 0);
    check("mreset_ser_valid", ser_valid, 0);
    check("mreset_done", done, 0);
    check("mreset_sh_ld", sh_ld, 0);
    step();
    rst_n = 1'b1;
    step();
    send_word(8'h5A, 1'b0, 1'b0, t0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
